// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: datapath widths, permutation size, key length,
// controller state encoding and key byte selection.
package arc4_pkg;
    localparam int DATA_W  = 8;
    localparam int S_SIZE  = 256;
    localparam int KEY_LEN = 3;
    localparam int KEY_W   = DATA_W * KEY_LEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_LEN,
        ST_PRGA,
        ST_DONE
    } state_t;

    // Key byte 0 is the most significant byte of the packed key.
    function automatic logic [DATA_W-1:0] key_byte(input logic [KEY_W-1:0] key,
                                                   input logic [1:0]       idx);
        case (idx)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    endfunction
endpackage

// File: rtl/arc4_encrypt_if.sv
// Start handshake, key and plaintext/ciphertext memory bus of arc4_encrypt.
// The slave modport is the encryptor; the master modport is its environment.
interface arc4_encrypt_if;
    import arc4_pkg::*;

    logic              en;
    logic              rdy;
    logic [KEY_W-1:0]  key;
    logic [DATA_W-1:0] pt_addr;
    logic [DATA_W-1:0] pt_rddata;
    logic [DATA_W-1:0] ct_addr;
    logic [DATA_W-1:0] ct_wrdata;
    logic              ct_wren;

    modport master (
        output en, key, pt_rddata,
        input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren
    );

    modport slave (
        input  en, key, pt_rddata,
        output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren
    );
endinterface

// File: rtl/s_mem.sv
// ARC4 permutation store: 256x8 single-port RAM with a registered read.
// A read in the same cycle as a write to that address returns the old byte.
module s_mem
    import arc4_pkg::*;
(
    input  logic [DATA_W-1:0] address,
    input  logic              clk,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [S_SIZE];

    // Synchronous write and registered read on the single port.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end
endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor for a length-prefixed message: builds S (INIT, KSA), copies
// the length byte (LEN), then writes one ciphertext byte per PRGA step.
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    arc4_encrypt_if.slave bus
);
    state_t            state;
    logic [2:0]        phase;
    logic [DATA_W-1:0] i, j, si, sj, len;
    logic [8:0]        k;
    logic [1:0]        kidx;
    logic [KEY_W-1:0]  key_q;

    logic [DATA_W-1:0] s_addr, s_data, s_q;
    logic              s_wren;
    logic [DATA_W-1:0] j_ksa, j_prga;

    // s_q holds S[i] in the cycle after the S[i] read in both schedules.
    assign j_ksa  = j + s_q + key_byte(key_q, kidx);
    assign j_prga = j + s_q;

    s_mem u_s_mem (
        .address (s_addr),
        .clk     (clk),
        .data    (s_data),
        .wren    (s_wren),
        .q       (s_q)
    );

    // S-RAM port steering: the single port is shared by reads and both swap writes.
    always_comb begin
        s_addr = i;
        s_data = i;
        s_wren = 1'b0;
        case (state)
            ST_INIT: s_wren = 1'b1;
            ST_KSA: begin
                case (phase)
                    3'd1: s_addr = j_ksa;
                    3'd2: begin s_data = s_q; s_wren = 1'b1; end
                    3'd3: begin s_addr = j; s_data = si; s_wren = 1'b1; end
                    default: ;
                endcase
            end
            ST_PRGA: begin
                case (phase)
                    3'd0: s_addr = i + 8'd1;
                    3'd1: s_addr = j_prga;
                    3'd2: begin s_data = s_q; s_wren = 1'b1; end
                    3'd3: begin s_addr = j; s_data = si; s_wren = 1'b1; end
                    3'd4: s_addr = si + sj;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Controller: sequences INIT/KSA/LEN/PRGA and registers all bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            phase         <= 3'd0;
            bus.rdy       <= 1'b1;
            bus.ct_wren   <= 1'b0;
            bus.pt_addr   <= '0;
            bus.ct_addr   <= '0;
            bus.ct_wrdata <= '0;
            i             <= '0;
            j             <= '0;
            si            <= '0;
            sj            <= '0;
            len           <= '0;
            k             <= '0;
            kidx          <= '0;
            key_q         <= '0;
        end else begin
            bus.ct_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.en && bus.rdy) begin
                        bus.rdy <= 1'b0;
                        key_q   <= bus.key;
                        i       <= '0;
                        j       <= '0;
                        kidx    <= '0;
                        phase   <= 3'd0;
                        state   <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    i <= i + 8'd1;
                    if (i == 8'hFF) begin
                        state <= ST_KSA;
                    end
                end
                ST_KSA: begin
                    phase <= phase + 3'd1;
                    if (phase == 3'd1) begin
                        j  <= j_ksa;
                        si <= s_q;
                    end else if (phase == 3'd3) begin
                        phase <= 3'd0;
                        i     <= i + 8'd1;
                        kidx  <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                        if (i == 8'hFF) begin
                            j           <= '0;
                            bus.pt_addr <= '0;
                            state       <= ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    phase <= phase + 3'd1;
                    if (phase == 3'd1) begin
                        len           <= bus.pt_rddata;
                        bus.ct_addr   <= '0;
                        bus.ct_wrdata <= bus.pt_rddata;
                        bus.ct_wren   <= 1'b1;
                    end else if (phase == 3'd2) begin
                        phase <= 3'd0;
                        k     <= 9'd1;
                        state <= (len == 8'd0) ? ST_DONE : ST_PRGA;
                    end
                end
                ST_PRGA: begin
                    phase <= phase + 3'd1;
                    case (phase)
                        3'd0: begin
                            i           <= i + 8'd1;
                            bus.pt_addr <= k[7:0];
                        end
                        3'd1: begin
                            j  <= j_prga;
                            si <= s_q;
                        end
                        3'd2: sj <= s_q;
                        3'd5: begin
                            phase         <= 3'd0;
                            bus.ct_addr   <= k[7:0];
                            bus.ct_wrdata <= bus.pt_rddata ^ s_q;
                            bus.ct_wren   <= 1'b1;
                            k             <= k + 9'd1;
                            if (k == {1'b0, len}) begin
                                state <= ST_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_DONE: begin
                    bus.rdy <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/arc4_encrypt.md
ARC4_ENCRYPT -- requirements
Module: arc4_encrypt

Interface
REQ-001 The block SHALL have these ports:
  clk  input  1  system clock; all state changes on rising edge.
  reset  input  1  asynchronous, active-low reset.
  en  input  1  start request, sampled only while rdy=1.
  rdy  output  1  high = idle and able to accept en.
  key  input  24  ARC4 key; key[23:16] is key byte 0, key[7:0] is key byte 2.
  pt_addr  output  8  plaintext memory read address.
  pt_rddata  input  8  plaintext memory data, valid 1 cycle after pt_addr.
  ct_addr  output  8  ciphertext memory address.
  ct_wrdata  output  8  ciphertext write data.
  ct_wren  output  1  ciphertext write strobe, one byte per asserted cycle.

Function
REQ-002 Plaintext memory SHALL hold a length-prefixed message: byte 0 = length L (0..255), bytes 1..L = message.
REQ-003 On completion, ct[0] SHALL equal L and ct[k] SHALL equal pt[k] XOR pad[k] for k=1..L, with pad[k] the k-th ARC4 keystream byte for key (key length 3).
REQ-004 ct locations above L SHALL NOT be written.
REQ-005 Handshake: en=1 while rdy=1 SHALL start an operation; rdy SHALL fall on the next edge and stay low until done.
REQ-006 en while rdy=0 SHALL be ignored; holding en high SHALL NOT start a second operation until rdy has been high for at least one cycle.
REQ-007 key SHALL be latched at start; key changes during an operation SHALL have no effect.
REQ-008 States SHALL be: IDLE, INIT (S[i]=i, i=0..255), KSA (j=j+S[i]+key[i mod 3]; swap S[i],S[j]), LEN (read pt[0], write ct[0]), PRGA (per k: i=i+1; j=j+S[i]; swap; pad=S[(S[i]+S[j]) mod 256]; read pt[k]; write ct[k]), DONE (one cycle, then IDLE with rdy=1).
REQ-009 All index arithmetic (i, j, sums) SHALL be 8-bit modulo 256; the PRGA byte counter SHALL be 9-bit so L=255 terminates correctly.
REQ-010 LEN SHALL go directly to DONE when L=0.
REQ-011 S SHALL be reinitialised on every operation; no state from a previous run SHALL affect the output.
REQ-012 Total latency from start to rdy=1 SHALL NOT exceed 256 + 256*5 + 4 + L*8 cycles.
REQ-013 ct_wren SHALL be high for exactly L+1 cycles per operation and low in IDLE.

Reset
REQ-014 reset=0 SHALL force, asynchronously: state IDLE, rdy=1, ct_wren=0, pt_addr=0, ct_addr=0, ct_wrdata=0, i=j=0.
REQ-015 Reset mid-operation SHALL abort with no further ct writes; the next en SHALL run a complete, correct operation.

Structure
REQ-016 State encoding enum and constants (S size 256, key length 3) SHALL live in shared package arc4_pkg.
REQ-017 The S array SHALL be a sub-module s_mem: 256x8 single-port RAM, 1-cycle registered read, same port order as ct_mem/pt_mem.
REQ-018 The block SHALL NOT read ct memory; it is a pure writer of ct and pure reader of pt.

Verification
REQ-019 key=0x4B6579 ("Key"), pt = 09 "Plaintext" -> ct[0..9] = 09 BB F3 16 E8 D9 40 AF 0A D3; ct[10] untouched.
REQ-020 L=0, any key -> exactly one ct write (ct[0]=00), rdy returns high.
REQ-021 L=255 random plaintext, key=0x000018 -> 256 writes; arc4 decryption of result with same key reproduces pt exactly.
REQ-022 Reset pulsed 500 cycles into an operation -> ct_wren=0 immediately, rdy=1; rerun of REQ-019 vector then yields the correct ciphertext.
REQ-023 en held high continuously, key changed mid-run -> each run uses its start-time key; rdy high at least one cycle between runs; outputs match the model.
